// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: multi-cycle radix-2 restoring divider sequencer for DIV/DIVU.
// Holds the pipeline through stall_req while dividing, then loads quotient
// into lo and remainder into hi with a one-cycle result_valid strobe.
// Optional build macro: DIV_EARLY_OUT_EN skips the dividend's leading zeros
// so that small dividends finish sooner.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a divide; stall_req asserted on the accept cycle
// BUSY  | one restoring quotient bit per cycle, pipeline held
// DONE  | hi/lo freshly loaded, result_valid pulses unless annulled
module div_seq_ctrl #(
  parameter int         DATA_WIDTH = 32,
  parameter logic [5:0] FUNCT_DIV  = 6'b011010,
  parameter logic [5:0] FUNCT_DIVU = 6'b011011
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [5:0]            funct,
  input  logic                  start,
  input  logic                  annul,
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  output logic                  stall_req,
  output logic                  result_valid,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [CW-1:0]         cnt_q;
  logic                  q_neg_q, r_neg_q;

  logic                  is_signed, is_div, accept, div_zero, a_zero, last;
  logic [DATA_WIDTH-1:0] abs_a, abs_b, quo_init;
  logic [CW-1:0]         cnt_init;
  logic [DATA_WIDTH:0]   r_sh;
  logic                  ge;
  logic [DATA_WIDTH-1:0] rem_nxt, quo_nxt;

`ifdef DIV_EARLY_OUT_EN
  localparam int ZW = CW + 1;
  logic [ZW-1:0] clz_a;

  function automatic logic [ZW-1:0] clz(input logic [DATA_WIDTH-1:0] v);
    clz = ZW'(DATA_WIDTH);
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (v[i]) clz = ZW'(DATA_WIDTH - 1 - i);
    end
  endfunction
`endif

  // Decode, operand magnitudes and one restoring step
  always_comb begin
    is_signed = (funct == FUNCT_DIV);
    is_div    = start & ((funct == FUNCT_DIV) | (funct == FUNCT_DIVU));
    accept    = (state_q == IDLE) & is_div & ~annul;
    div_zero  = (operand_b == '0);
    abs_a     = (is_signed & operand_a[DATA_WIDTH-1]) ? -operand_a : operand_a;
    abs_b     = (is_signed & operand_b[DATA_WIDTH-1]) ? -operand_b : operand_b;
`ifdef DIV_EARLY_OUT_EN
    clz_a     = clz(abs_a);
    a_zero    = (abs_a == '0);
    quo_init  = abs_a << clz_a;
    cnt_init  = clz_a[CW-1:0];
`else
    a_zero    = 1'b0;
    quo_init  = abs_a;
    cnt_init  = '0;
`endif
    last      = (cnt_q == CW'(DATA_WIDTH - 1));
    // Shifted partial remainder can need one extra bit before the compare
    r_sh      = {rem_q, quo_q[DATA_WIDTH-1]};
    ge        = (r_sh >= {1'b0, dvs_q});
    rem_nxt   = ge ? (r_sh[DATA_WIDTH-1:0] - dvs_q) : r_sh[DATA_WIDTH-1:0];
    quo_nxt   = {quo_q[DATA_WIDTH-2:0], ge};
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state, stall request and result strobe
  always_comb begin
    state_d      = state_q;
    stall_req    = 1'b0;
    result_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          stall_req = 1'b1;
          state_d   = (div_zero | a_zero) ? DONE : BUSY;
        end
      end
      BUSY: begin
        stall_req = 1'b1;
        if (annul)     state_d = IDLE;
        else if (last) state_d = DONE;
      end
      DONE: begin
        result_valid = ~annul;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Divider datapath and hi/lo result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            rem_q   <= '0;
            quo_q   <= quo_init;
            dvs_q   <= abs_b;
            cnt_q   <= cnt_init;
            q_neg_q <= is_signed & (operand_a[DATA_WIDTH-1] ^ operand_b[DATA_WIDTH-1]);
            r_neg_q <= is_signed & operand_a[DATA_WIDTH-1];
            // Divide-by-zero takes priority so results match the plain build
            if (div_zero) begin
              lo <= '1;
              hi <= operand_a;
            end else if (a_zero) begin
              lo <= '0;
              hi <= '0;
            end
          end
        end
        BUSY: begin
          if (!annul) begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            cnt_q <= cnt_q + CW'(1);
            if (last) begin
              lo <= q_neg_q ? -quo_nxt : quo_nxt;
              hi <= r_neg_q ? -rem_nxt : rem_nxt;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Scoreboard bench for div_seq_ctrl: stimulus pushes expected hi/lo and the
// cycle of result_valid; a negedge monitor pops and compares on each strobe.
module tb_div_seq_ctrl;

  localparam logic [5:0] F_DIV  = 6'b011010;
  localparam logic [5:0] F_DIVU = 6'b011011;

  logic        clk, rst_n, start, annul;
  logic [5:0]  funct;
  logic [31:0] operand_a, operand_b, hi, lo;
  logic        stall_req, result_valid;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  div_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .funct(funct), .start(start), .annul(annul),
    .operand_a(operand_a), .operand_b(operand_b), .stall_req(stall_req),
    .result_valid(result_valid), .hi(hi), .lo(lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain arithmetic on the architectural definition of DIV/DIVU
  function automatic exp_t model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    e.cyc = 0;
    if (b == 0) begin
      e.lo = 32'hFFFF_FFFF;
      e.hi = a;
    end else if (sgn) begin
      if (sb == -1) begin
        e.lo = -a;
        e.hi = 32'h0;
      end else begin
        e.lo = sa / sb;
        e.hi = sa % sb;
      end
    end else begin
      e.lo = a / b;
      e.hi = a % b;
    end
    return e;
  endfunction

  function automatic int lat_of(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] m;
    int          bits;
    m    = (sgn && a[31]) ? -a : a;
    bits = 0;
    for (int i = 0; i < 32; i++) if (m[i]) bits = i + 1;
    if (b == 0) return 1;
`ifdef DIV_EARLY_OUT_EN
    return 1 + bits;
`else
    return 33;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    start     = 1'b1;
    funct     = sgn ? F_DIV : F_DIVU;
    operand_a = a;
    operand_b = b;
    #1;
    chk("stall_on_accept", 32'(stall_req), 32'd1);
    e     = model(sgn, a, b);
    e.cyc = cyc + lat_of(sgn, a, b);
    exp_q.push_back(e);
    tick();
    start = 1'b0;
    funct = 6'h00;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      chk("stall_busy", 32'(stall_req), 32'(cyc < exp_q[0].cyc));
      tick();
      n++;
    end
    if (exp_q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL result_timeout: got no result_valid expected one within %0d cycles", budget);
      exp_q.delete();
    end
  endtask

  // Monitor: every result strobe must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n === 1'b1 && result_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid: got result_valid=1 expected 0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("lo", lo, e.lo);
        chk("hi", hi, e.hi);
        chk("valid_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat_a;
    rst_n = 1'b0; start = 1'b0; annul = 1'b0; funct = 6'h00;
    operand_a = '0; operand_b = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    chk("reset_valid", 32'(result_valid), 32'h0);
    chk("reset_stall", 32'(stall_req), 32'h0);

    // Directed cases
    issue(1'b0, 32'd100, 32'd7);                  wait_done(60);
    issue(1'b1, 32'hFFFF_FFF9, 32'd2);            wait_done(60);
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);    wait_done(60);
    issue(1'b0, 32'd5, 32'd0);                    wait_done(60);
    issue(1'b1, 32'h0000_0000, 32'd3);            wait_done(60);

    // Annul mid-divide: hi/lo keep the 100/7 result, no strobe, relaunch works
    issue(1'b0, 32'd100, 32'd7);                  wait_done(60);
    issue(1'b0, 32'd100, 32'd7);
    lat_a = lat_of(1'b0, 32'd100, 32'd7);
    repeat (9) tick();
    annul = 1'b1;
    if (lat_a > 10) void'(exp_q.pop_back());
    tick();
    annul = 1'b0;
    chk("annul_hold_hi", hi, 32'd2);
    chk("annul_hold_lo", lo, 32'd14);
    chk("annul_idle_stall", 32'(stall_req), 32'h0);
    issue(1'b0, 32'd9, 32'd3);                    wait_done(60);

    // Annul on the would-be accept cycle and a non-divide funct: both ignored
    start = 1'b1; funct = F_DIVU; annul = 1'b1; operand_a = 32'd50; operand_b = 32'd5;
    #1 chk("annul_accept_stall", 32'(stall_req), 32'h0);
    tick();
    start = 1'b1; funct = 6'h20; annul = 1'b0;
    #1 chk("nondiv_stall", 32'(stall_req), 32'h0);
    tick();
    start = 1'b0; funct = 6'h00;
    repeat (40) tick();
    chk("ignored_hi", hi, 32'd0);
    chk("ignored_lo", lo, 32'd3);

    // Reset pulse mid-divide clears everything at once
    issue(1'b1, 32'hFFFF_FF00, 32'd7);
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_hi", hi, 32'h0);
    chk("midrst_lo", lo, 32'h0);
    chk("midrst_valid", 32'(result_valid), 32'h0);
    chk("midrst_stall", 32'(stall_req), 32'h0);
    exp_q.delete();
    #1 rst_n = 1'b1;
    repeat (40) tick();
    chk("postrst_lo", lo, 32'h0);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      bit          sgn;
      logic [31:0] a, b;
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'h0;
        1, 2:    b = $urandom_range(1, 20);
        3:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       a = $urandom_range(0, 300);
        1:       a = 32'h8000_0000;
        default: ;
      endcase
      issue(sgn, a, b);
      wait_done(60);
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (40) tick();
    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
